// File: rtl/i2c_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_pkg : shared state encoding and constants for the I2C write engine    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package i2c_pkg;

  localparam int unsigned I2C_LEN_W     = 8;
  localparam logic        I2C_WRITE_BIT = 1'b0;

  localparam int unsigned STATE_W = 4;
  localparam logic [STATE_W-1:0] S_IDLE    = 4'd0;
  localparam logic [STATE_W-1:0] S_START_A = 4'd1;
  localparam logic [STATE_W-1:0] S_START_B = 4'd2;
  localparam logic [STATE_W-1:0] S_LOAD    = 4'd3;
  localparam logic [STATE_W-1:0] S_WAIT    = 4'd4;
  localparam logic [STATE_W-1:0] S_FETCH   = 4'd5;
  localparam logic [STATE_W-1:0] S_STOP_A  = 4'd6;
  localparam logic [STATE_W-1:0] S_STOP_B  = 4'd7;
  localparam logic [STATE_W-1:0] S_STOP_C  = 4'd8;

endpackage
`default_nettype wire

// File: rtl/i2c_bus_cond_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_bus_cond_gen : START/STOP line levels and SCL-high wait qualifier;   |
// | I2C_STRETCH_TIMEOUT_EN adds a bounded wait with a timeout strobe.        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module i2c_bus_cond_gen
  import i2c_pkg::*;
`ifdef I2C_STRETCH_TIMEOUT_EN
#(
  parameter int unsigned STRETCH_TIMEOUT = 1024
)
`endif
(
`ifdef I2C_STRETCH_TIMEOUT_EN
  input  logic               i_clk,
  input  logic               i_rst,
  output logic               o_timeout,
`endif
  input  logic               i_tick,
  input  logic               i_scl,
  input  logic [STATE_W-1:0] i_state,
  output logic               o_scl,
  output logic               o_sda,
  output logic               o_step
);

  logic w_wait_high;

  assign w_wait_high = (i_state == S_START_A) || (i_state == S_STOP_B);
  assign o_step      = w_wait_high & i_tick & i_scl;

  // Sequencer-owned levels; during byte phases the byte controller owns the bus.
  always_comb begin
    o_scl = 1'b1;
    o_sda = 1'b1;
    case (i_state)
      S_START_B: begin o_scl = 1'b1; o_sda = 1'b0; end
      S_LOAD, S_WAIT, S_FETCH, S_STOP_A: begin o_scl = 1'b0; o_sda = 1'b0; end
      S_STOP_B, S_STOP_C: begin o_scl = 1'b1; o_sda = 1'b0; end
      default: begin o_scl = 1'b1; o_sda = 1'b1; end
    endcase
  end

`ifdef I2C_STRETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(STRETCH_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             w_stretch_tick;

  assign w_stretch_tick = w_wait_high & i_tick & ~i_scl;
  assign o_timeout      = w_stretch_tick && (cnt_q == CNT_W'(STRETCH_TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!w_wait_high)        cnt_d = '0;
    else if (w_stretch_tick) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`endif

endmodule
`default_nettype wire

// File: rtl/i2c_master_write_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_master_write_sequencer : START, address+W, N data bytes, STOP.       |
// | Optional I2C_STRETCH_TIMEOUT_EN bounds SCL-high waits (adds o_timeout).  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module i2c_master_write_sequencer
  import i2c_pkg::*;
#(
  parameter int unsigned LEN_W = I2C_LEN_W
`ifdef I2C_STRETCH_TIMEOUT_EN
  , parameter int unsigned STRETCH_TIMEOUT = 1024
`endif
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_tick,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [6:0]       i_addr,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_wr_valid,
  input  logic [7:0]       i_wr_data,
  output logic             o_wr_ready,
  output logic             o_byte_start,
  output logic [7:0]       o_byte_data,
  input  logic             i_byte_done,
  input  logic             i_byte_error,
  input  logic             i_scl,
  output logic             o_scl,
  output logic             o_sda,
  output logic             o_bus_sel,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_nack
`ifdef I2C_STRETCH_TIMEOUT_EN
  , output logic           o_timeout
`endif
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [6:0]         addr_q;
  logic [LEN_W-1:0]   rem_q;
  logic [7:0]         byte_q;
  logic               nack_flag_q;
  logic               done_q;
  logic               nack_q;
  logic               w_step;
  logic               w_timeout;

`ifdef I2C_STRETCH_TIMEOUT_EN
  logic timeout_q;

  i2c_bus_cond_gen #(.STRETCH_TIMEOUT(STRETCH_TIMEOUT)) u_cond (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .o_timeout(w_timeout),
    .i_tick   (i_tick),
    .i_scl    (i_scl),
    .i_state  (state_q),
    .o_scl    (o_scl),
    .o_sda    (o_sda),
    .o_step   (w_step)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) timeout_q <= 1'b0;
    else       timeout_q <= w_timeout;
  end

  assign o_timeout = timeout_q;
`else
  assign w_timeout = 1'b0;

  i2c_bus_cond_gen u_cond (
    .i_tick (i_tick),
    .i_scl  (i_scl),
    .i_state(state_q),
    .o_scl  (o_scl),
    .o_sda  (o_sda),
    .o_step (w_step)
  );
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (i_cmd_valid) state_d = S_START_A;
      S_START_A: begin
        if (w_timeout)   state_d = S_IDLE;
        else if (w_step) state_d = S_START_B;
      end
      S_START_B: if (i_tick) state_d = S_LOAD;
      S_LOAD:    state_d = S_WAIT;
      // An error in the same cycle as done still ends the transfer as a NACK.
      S_WAIT: begin
        if (i_byte_error)     state_d = S_STOP_A;
        else if (i_byte_done) state_d = (rem_q == '0) ? S_STOP_A : S_FETCH;
      end
      S_FETCH:   if (i_wr_valid) state_d = S_LOAD;
      S_STOP_A:  if (i_tick) state_d = S_STOP_B;
      S_STOP_B: begin
        if (w_timeout)   state_d = S_IDLE;
        else if (w_step) state_d = S_STOP_C;
      end
      S_STOP_C:  if (i_tick) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_q      <= '0;
      rem_q       <= '0;
      byte_q      <= '0;
      nack_flag_q <= 1'b0;
      done_q      <= 1'b0;
      nack_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      nack_q <= 1'b0;
      case (state_q)
        S_IDLE: if (i_cmd_valid) begin
          addr_q      <= i_addr;
          rem_q       <= i_len;
          nack_flag_q <= 1'b0;
        end
        S_START_B: if (i_tick) byte_q <= {addr_q, I2C_WRITE_BIT};
        S_WAIT:    if (i_byte_error) nack_flag_q <= 1'b1;
        S_FETCH: if (i_wr_valid) begin
          byte_q <= i_wr_data;
          rem_q  <= rem_q - LEN_W'(1);
        end
        S_STOP_C: if (i_tick) begin
          done_q <= ~nack_flag_q;
          nack_q <= nack_flag_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_cmd_ready  = (state_q == S_IDLE);
    o_busy       = (state_q != S_IDLE);
    o_bus_sel    = (state_q == S_LOAD) || (state_q == S_WAIT) || (state_q == S_FETCH);
    o_byte_start = (state_q == S_LOAD);
    o_wr_ready   = (state_q == S_FETCH) && i_wr_valid;
    o_byte_data  = byte_q;
    o_done       = done_q;
    o_nack       = nack_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_write_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_i2c_master_write_sequencer : scoreboard bench with a byte-controller  |
// | responder, SCL stretch model and a transaction-level reference model.    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_i2c_master_write_sequencer;

  localparam int LEN_W    = 8;
  localparam int TICK_DIV = 4;

  localparam logic [1:0] EV_BYTE    = 2'd0;
  localparam logic [1:0] EV_DONE    = 2'd1;
  localparam logic [1:0] EV_NACK    = 2'd2;
  localparam logic [1:0] EV_TIMEOUT = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
  } ev_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             tick = 1'b0;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [6:0]       addr;
  logic [LEN_W-1:0] len;
  logic             wr_valid;
  logic [7:0]       wr_data;
  logic             wr_ready;
  logic             byte_start;
  logic [7:0]       byte_data;
  logic             byte_done;
  logic             byte_err;
  logic             scl_in;
  logic             scl_out;
  logic             sda_out;
  logic             bus_sel;
  logic             busy;
  logic             done;
  logic             nack;
  logic             stretch = 1'b0;
`ifdef I2C_STRETCH_TIMEOUT_EN
  logic             timeout;
`endif

  int   checks = 0;
  int   errors = 0;
  ev_t  sb_q[$];
  logic [7:0] data_q[$];
  int   start_cnt, stop_cnt, wr_cnt, started_cnt, acked_cnt;
  int   hold_idx = 1000;
  int   nack_at = -1;
  int   txn_len = 0;
  bit   stop_stretch = 1'b0;
  bit   end_seen = 1'b0;
  logic prev_scl = 1'b1;
  logic prev_sda = 1'b1;
  int   tick_ph = 0;

  assign scl_in = scl_out & ~stretch;

  i2c_master_write_sequencer #(
    .LEN_W(LEN_W)
`ifdef I2C_STRETCH_TIMEOUT_EN
    , .STRETCH_TIMEOUT(8)
`endif
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_tick      (tick),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_addr      (addr),
    .i_len       (len),
    .i_wr_valid  (wr_valid),
    .i_wr_data   (wr_data),
    .o_wr_ready  (wr_ready),
    .o_byte_start(byte_start),
    .o_byte_data (byte_data),
    .i_byte_done (byte_done),
    .i_byte_error(byte_err),
    .i_scl       (scl_in),
    .o_scl       (scl_out),
    .o_sda       (sda_out),
    .o_bus_sel   (bus_sel),
    .o_busy      (busy),
    .o_done      (done),
    .o_nack      (nack)
`ifdef I2C_STRETCH_TIMEOUT_EN
    , .o_timeout (timeout)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tick    = (tick_ph == 0);
      tick_ph = (tick_ph + 1) % TICK_DIV;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_cmp(input logic [1:0] kind, input logic [7:0] data);
    ev_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected: got event kind %0d with no expectation at %0t", kind, $time);
    end else begin
      e = sb_q.pop_front();
      chk("event_kind", {30'd0, kind}, {30'd0, e.kind});
      if (e.kind == EV_BYTE && kind == EV_BYTE) chk("byte_data", {24'd0, data}, {24'd0, e.data});
    end
  endtask

  // Monitor: bus conditions, wr_ready count, and scoreboard pops on DUT events.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_scl && scl_out && prev_sda && !sda_out) start_cnt++;
      if (prev_scl && scl_out && !prev_sda && sda_out) stop_cnt++;
      if (wr_ready) wr_cnt++;
      if (byte_start) begin
        chk("start_before_byte", start_cnt, 1);
        chk("no_stop_before_byte", stop_cnt, 0);
        pop_cmp(EV_BYTE, byte_data);
      end
      if (done) begin pop_cmp(EV_DONE, 8'h00); end_seen = 1'b1; end
      if (nack) begin pop_cmp(EV_NACK, 8'h00); end_seen = 1'b1; end
`ifdef I2C_STRETCH_TIMEOUT_EN
      if (timeout) begin pop_cmp(EV_TIMEOUT, 8'h00); end_seen = 1'b1; end
`endif
    end
    prev_scl = scl_out;
    prev_sda = sda_out;
  end

  // Byte-controller model: acknowledges each started byte after a random delay.
  initial begin
    int idx;
    int d;
    byte_done = 1'b0;
    byte_err  = 1'b0;
    forever begin
      @(negedge clk);
      if (byte_start && !rst) begin
        idx = started_cnt;
        started_cnt++;
        if (idx < hold_idx) begin
          d = $urandom_range(1, 5);
          repeat (d) @(posedge clk);
          #1;
          if (idx == nack_at) begin
            byte_err  = 1'b1;
            byte_done = 1'b1;
          end else begin
            byte_done = 1'b1;
            acked_cnt++;
            if (idx == txn_len && stop_stretch) stretch = 1'b1;
          end
          @(posedge clk);
          #1;
          byte_done = 1'b0;
          byte_err  = 1'b0;
        end
      end
    end
  end

  task automatic feed(input int n_fetch, input int stall_idx);
    int guard;
    int bad;
    for (int k = 0; k < n_fetch; k++) begin
      guard = 0;
      while (acked_cnt < k + 1 && guard < 2000) begin @(negedge clk); guard++; end
      if (acked_cnt < k + 1) begin chk("feed_wait_ack", 0, 1); break; end
      if (k == stall_idx) begin
        bad = 0;
        repeat (50) begin
          @(negedge clk);
          if (scl_out || byte_start || !busy) bad++;
        end
        chk("stall_hold", bad, 0);
      end else begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      @(posedge clk);
      #1;
      wr_valid = 1'b1;
      wr_data  = data_q[k];
      guard = 0;
      do begin @(negedge clk); guard++; end while (!wr_ready && guard < 2000);
      if (!wr_ready) chk("feed_wr_ready", 0, 1);
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
    end
  endtask

  task automatic issue_cmd(input logic [6:0] a, input int n);
    @(posedge clk);
    #1;
    start_cnt = 0; stop_cnt = 0; wr_cnt = 0;
    started_cnt = 0; acked_cnt = 0; end_seen = 1'b0;
    cmd_valid = 1'b1;
    addr      = a;
    len       = LEN_W'(n);
    @(negedge clk);
    chk("cmd_ready", {31'd0, cmd_ready}, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Reference model: address+W then data in order; a NACK at byte j ends after byte j.
  task automatic run_txn(input logic [6:0] a, input int n, input int nk, input int stall_idx,
                         input bit stretch_stop);
    int n_sent;
    int guard;
    int ticks;
    int bad;
    int exp_stops;
    bit to;
    logic [1:0] end_kind;
    to = 1'b0;
`ifdef I2C_STRETCH_TIMEOUT_EN
    to = stretch_stop;
`endif
    n_sent   = (nk >= 0) ? nk + 1 : n + 1;
    sb_q.push_back('{kind: EV_BYTE, data: {a, 1'b0}});
    for (int i = 0; i < n_sent - 1; i++) sb_q.push_back('{kind: EV_BYTE, data: data_q[i]});
    end_kind = (nk >= 0) ? EV_NACK : (to ? EV_TIMEOUT : EV_DONE);
    sb_q.push_back('{kind: end_kind, data: 8'h00});
    exp_stops    = to ? 0 : 1;
    nack_at      = nk;
    txn_len      = n;
    stop_stretch = stretch_stop;
    issue_cmd(a, n);
    fork
      feed(n_sent - 1, stall_idx);
      begin
        if (stretch_stop) begin
          guard = 0;
          while (!stretch && guard < 5000) begin @(negedge clk); guard++; end
          chk("stretch_reached", {31'd0, stretch}, 1);
          ticks = 0;
          bad   = 0;
          while (ticks < 20) begin
            @(negedge clk);
            if (tick) ticks++;
            if (stop_cnt != 0) bad++;
          end
          chk("stretch_no_stop", bad, 0);
          @(posedge clk);
          #1;
          stretch = 1'b0;
        end
        guard = 0;
        while (!end_seen && guard < 5000) begin @(negedge clk); guard++; end
        chk("txn_end_seen", {31'd0, end_seen}, 1);
      end
    join
    repeat (3) @(negedge clk);
    chk("wr_ready_count", wr_cnt, n_sent - 1);
    chk("start_count", start_cnt, 1);
    chk("stop_count", stop_cnt, exp_stops);
    chk("idle_busy", {31'd0, busy}, 0);
    chk("idle_lines", {30'd0, scl_out, sda_out}, 2'b11);
    chk("sb_drained", sb_q.size(), 0);
    stop_stretch = 1'b0;
    nack_at      = -1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_scl", {31'd0, scl_out}, 1);
    chk("rst_sda", {31'd0, sda_out}, 1);
    chk("rst_bus_sel", {31'd0, bus_sel}, 0);
    chk("rst_byte_start", {31'd0, byte_start}, 0);
    chk("rst_byte_data", {24'd0, byte_data}, 0);
    chk("rst_wr_ready", {31'd0, wr_ready}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_nack", {31'd0, nack}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
`ifdef I2C_STRETCH_TIMEOUT_EN
    chk("rst_timeout", {31'd0, timeout}, 0);
`endif
  endtask

  task automatic fill(input int n);
    data_q.delete();
    for (int i = 0; i < n; i++) data_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic run_reset_mid_wait();
    int guard;
    fill(3);
    sb_q.push_back('{kind: EV_BYTE, data: {7'h2B, 1'b0}});
    sb_q.push_back('{kind: EV_BYTE, data: data_q[0]});
    sb_q.push_back('{kind: EV_BYTE, data: data_q[1]});
    hold_idx = 2;
    txn_len  = 3;
    issue_cmd(7'h2B, 3);
    fork
      feed(2, -1);
      begin
        guard = 0;
        while (started_cnt < 3 && guard < 5000) begin @(negedge clk); guard++; end
        chk("reached_byte2", started_cnt, 3);
      end
    join
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    hold_idx = 1000;
    @(negedge clk);
    chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 1);
    chk("post_rst_no_stop", stop_cnt, 0);
    chk("post_rst_sb", sb_q.size(), 0);
  endtask

  initial begin
    int n;
    int nk;
    rst = 1'b1; cmd_valid = 1'b0; addr = '0; len = '0;
    wr_valid = 1'b0; wr_data = '0;
    start_cnt = 0; stop_cnt = 0; wr_cnt = 0; started_cnt = 0; acked_cnt = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    data_q = '{8'hA5, 8'h3C};
    run_txn(7'h50, 2, -1, -1, 1'b0);
    fill(3);
    run_txn(7'h21, 3, 2, -1, 1'b0);
    data_q.delete();
    run_txn(7'h7F, 0, -1, -1, 1'b0);
    fill(3);
    run_txn(7'h33, 3, -1, 1, 1'b0);
    fill(1);
    run_txn(7'h0A, 1, -1, -1, 1'b1);
    run_reset_mid_wait();
    for (int t = 0; t < 12; t++) begin
      n  = $urandom_range(0, 5);
      nk = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n) : -1;
      fill(n);
      run_txn(7'($urandom_range(0, 127)), n, nk, -1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
